// File: rtl/muldiv_rs.sv
// Reservation station for the M-extension multiply/divide unit.
// Tracks operand readiness by ROB tag, wakes on CDB, issues one op at a time.
module muldiv_rs #(
  parameter  int RS_DEPTH  = 4,
  parameter  int ROB_DEPTH = 4,
  localparam int TAGW      = $clog2(ROB_DEPTH),
  localparam int IW        = $clog2(RS_DEPTH),
  localparam int OW        = $clog2(RS_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            disp_valid,
  output logic            disp_ready,
  input  logic [31:0]     disp_instr,
  input  logic [TAGW-1:0] disp_rob,
  input  logic            disp_rs1_rdy,
  input  logic [31:0]     disp_rs1_v,
  input  logic [TAGW-1:0] disp_rs1_tag,
  input  logic            disp_rs2_rdy,
  input  logic [31:0]     disp_rs2_v,
  input  logic [TAGW-1:0] disp_rs2_tag,
  input  logic            cdb_valid,
  input  logic [TAGW-1:0] cdb_rob,
  input  logic [31:0]     cdb_data,
  output logic            fu_en,
  output logic [31:0]     fu_instr,
  output logic [31:0]     fu_rs1_v,
  output logic [31:0]     fu_rs2_v,
  output logic [TAGW-1:0] fu_rob,
  input  logic            fu_resp,
  output logic [OW-1:0]   occupancy,
  output logic            dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e              state_q;
  logic [RS_DEPTH-1:0] vld_q, r1_q, r2_q;
  logic [31:0]         instr_q [RS_DEPTH];
  logic [31:0]         v1_q    [RS_DEPTH];
  logic [31:0]         v2_q    [RS_DEPTH];
  logic [TAGW-1:0]     rob_q   [RS_DEPTH];
  logic [TAGW-1:0]     t1_q    [RS_DEPTH];
  logic [TAGW-1:0]     t2_q    [RS_DEPTH];

  logic            fu_en_q;
  logic [31:0]     fu_instr_q, fu_rs1_q, fu_rs2_q;
  logic [TAGW-1:0] fu_rob_q;
  logic [OW-1:0]   occ_q, occ_d;

  logic [RS_DEPTH-1:0] ready_vec;
  logic [IW-1:0]       alloc_idx, iss_idx;
  logic                disp_fire, issue_fire, byp1, byp2;

  // Dispatch handshake: an op transfers on an edge where disp_valid & disp_ready;
  // disp_ready depends on registered occupancy only, never on a same-cycle issue.
  assign disp_ready = ~&vld_q;
  assign ready_vec  = vld_q & r1_q & r2_q;
  assign disp_fire  = disp_valid & disp_ready;
  assign issue_fire = (state_q == IDLE) & (|ready_vec);
  assign byp1       = ~disp_rs1_rdy & cdb_valid & (disp_rs1_tag == cdb_rob);
  assign byp2       = ~disp_rs2_rdy & cdb_valid & (disp_rs2_tag == cdb_rob);
  assign occ_d      = occ_q + OW'(disp_fire) - OW'(issue_fire);

  // Descending scans leave the lowest matching index selected.
  always_comb begin
    alloc_idx = '0;
    iss_idx   = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!vld_q[i])    alloc_idx = IW'(i);
      if (ready_vec[i]) iss_idx   = IW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_q      <= '0;
      state_q    <= IDLE;
      fu_en_q    <= 1'b0;
      fu_instr_q <= '0;
      fu_rs1_q   <= '0;
      fu_rs2_q   <= '0;
      fu_rob_q   <= '0;
      occ_q      <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (vld_q[i] && cdb_valid) begin
          if (!r1_q[i] && t1_q[i] == cdb_rob) begin
            r1_q[i] <= 1'b1;
            v1_q[i] <= cdb_data;
          end
          if (!r2_q[i] && t2_q[i] == cdb_rob) begin
            r2_q[i] <= 1'b1;
            v2_q[i] <= cdb_data;
          end
        end
      end

      if (issue_fire) vld_q[iss_idx] <= 1'b0;

      // The allocated slot is invalid, so it never collides with wakeup or issue.
      if (disp_fire) begin
        vld_q[alloc_idx]   <= 1'b1;
        instr_q[alloc_idx] <= disp_instr;
        rob_q[alloc_idx]   <= disp_rob;
        r1_q[alloc_idx]    <= disp_rs1_rdy | byp1;
        v1_q[alloc_idx]    <= byp1 ? cdb_data : disp_rs1_v;
        t1_q[alloc_idx]    <= disp_rs1_tag;
        r2_q[alloc_idx]    <= disp_rs2_rdy | byp2;
        v2_q[alloc_idx]    <= byp2 ? cdb_data : disp_rs2_v;
        t2_q[alloc_idx]    <= disp_rs2_tag;
      end

      case (state_q)
        IDLE: begin
          if (issue_fire) begin
            state_q    <= BUSY;
            fu_en_q    <= 1'b1;
            fu_instr_q <= instr_q[iss_idx];
            fu_rs1_q   <= v1_q[iss_idx];
            fu_rs2_q   <= v2_q[iss_idx];
            fu_rob_q   <= rob_q[iss_idx];
          end
        end
        BUSY: begin
          if (fu_resp) begin
            state_q <= IDLE;
            fu_en_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      occ_q <= occ_d;
    end
  end

  assign fu_en       = fu_en_q;
  assign fu_instr    = fu_instr_q;
  assign fu_rs1_v    = fu_rs1_q;
  assign fu_rs2_v    = fu_rs2_q;
  assign fu_rob      = fu_rob_q;
  assign occupancy   = occ_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_rs.sv
// Bench for muldiv_rs: directed scenarios plus a randomized run against an
// entry-list reference model stepped once per clock edge.
module tb_muldiv_rs;
  localparam int RS_DEPTH  = 4;
  localparam int ROB_DEPTH = 4;
  localparam int TAGW      = 2;
  localparam int OW        = 3;
  localparam logic [31:0] MUL = 32'h0200_0033;
  localparam logic [31:0] DIV = 32'h0200_4033;

  logic clk = 1'b0;
  logic rst = 1'b1, flush = 1'b0;
  logic disp_valid = 1'b0, disp_ready;
  logic [31:0] disp_instr = '0, disp_rs1_v = '0, disp_rs2_v = '0;
  logic [TAGW-1:0] disp_rob = '0, disp_rs1_tag = '0, disp_rs2_tag = '0;
  logic disp_rs1_rdy = 1'b0, disp_rs2_rdy = 1'b0;
  logic cdb_valid = 1'b0;
  logic [TAGW-1:0] cdb_rob = '0;
  logic [31:0] cdb_data = '0;
  logic fu_en, fu_resp = 1'b0, dbg_state;
  logic [31:0] fu_instr, fu_rs1_v, fu_rs2_v;
  logic [TAGW-1:0] fu_rob;
  logic [OW-1:0] occupancy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  muldiv_rs #(.RS_DEPTH(RS_DEPTH), .ROB_DEPTH(ROB_DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_instr(disp_instr),
    .disp_rob(disp_rob), .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_v(disp_rs1_v),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_v(disp_rs2_v),
    .disp_rs2_tag(disp_rs2_tag), .cdb_valid(cdb_valid), .cdb_rob(cdb_rob),
    .cdb_data(cdb_data), .fu_en(fu_en), .fu_instr(fu_instr), .fu_rs1_v(fu_rs1_v),
    .fu_rs2_v(fu_rs2_v), .fu_rob(fu_rob), .fu_resp(fu_resp), .occupancy(occupancy),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit              v;
    logic [31:0]     instr;
    logic [TAGW-1:0] rob;
    bit              r1;
    logic [31:0]     v1;
    logic [TAGW-1:0] t1;
    bit              r2;
    logic [31:0]     v2;
    logic [TAGW-1:0] t2;
  } ent_t;

  ent_t            m_ent[RS_DEPTH];
  bit              m_busy = 1'b0;
  logic [31:0]     m_instr = '0, m_rs1 = '0, m_rs2 = '0;
  logic [TAGW-1:0] m_rob = '0;
  int              m_occ = 0;

  function automatic bit m_full();
    bit f = 1'b1;
    for (int i = 0; i < RS_DEPTH; i++) if (!m_ent[i].v) f = 1'b0;
    return f;
  endfunction

  task automatic model_edge();
    int ii;
    int ai;
    bit acc;
    ii = -1;
    ai = -1;
    if (rst || flush) begin
      for (int i = 0; i < RS_DEPTH; i++) m_ent[i].v = 1'b0;
      m_busy = 1'b0; m_instr = '0; m_rs1 = '0; m_rs2 = '0; m_rob = '0; m_occ = 0;
      return;
    end
    if (!m_busy)
      for (int i = 0; i < RS_DEPTH; i++)
        if (ii < 0 && m_ent[i].v && m_ent[i].r1 && m_ent[i].r2) ii = i;
    for (int i = 0; i < RS_DEPTH; i++) if (ai < 0 && !m_ent[i].v) ai = i;
    acc = disp_valid && (ai >= 0);
    if (ii >= 0) begin
      m_busy = 1'b1;
      m_instr = m_ent[ii].instr; m_rs1 = m_ent[ii].v1; m_rs2 = m_ent[ii].v2; m_rob = m_ent[ii].rob;
      m_ent[ii].v = 1'b0;
      m_occ--;
    end else if (m_busy && fu_resp) begin
      m_busy = 1'b0;
    end
    if (cdb_valid)
      for (int i = 0; i < RS_DEPTH; i++) if (m_ent[i].v) begin
        if (!m_ent[i].r1 && m_ent[i].t1 == cdb_rob) begin m_ent[i].r1 = 1'b1; m_ent[i].v1 = cdb_data; end
        if (!m_ent[i].r2 && m_ent[i].t2 == cdb_rob) begin m_ent[i].r2 = 1'b1; m_ent[i].v2 = cdb_data; end
      end
    if (acc) begin
      m_ent[ai].v = 1'b1; m_ent[ai].instr = disp_instr; m_ent[ai].rob = disp_rob;
      m_ent[ai].r1 = disp_rs1_rdy; m_ent[ai].v1 = disp_rs1_v; m_ent[ai].t1 = disp_rs1_tag;
      m_ent[ai].r2 = disp_rs2_rdy; m_ent[ai].v2 = disp_rs2_v; m_ent[ai].t2 = disp_rs2_tag;
      if (!disp_rs1_rdy && cdb_valid && disp_rs1_tag == cdb_rob) begin m_ent[ai].r1 = 1'b1; m_ent[ai].v1 = cdb_data; end
      if (!disp_rs2_rdy && cdb_valid && disp_rs2_tag == cdb_rob) begin m_ent[ai].r2 = 1'b1; m_ent[ai].v2 = cdb_data; end
      m_occ++;
    end
  endtask

  // ---------------- clock / driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    disp_valid = 1'b0; cdb_valid = 1'b0; fu_resp = 1'b0; flush = 1'b0;
  endtask

  task automatic disp(input logic [31:0] instr, input logic [TAGW-1:0] rob,
                      input logic r1, input logic [31:0] v1, input logic [TAGW-1:0] t1,
                      input logic r2, input logic [31:0] v2, input logic [TAGW-1:0] t2);
    disp_valid = 1'b1; disp_instr = instr; disp_rob = rob;
    disp_rs1_rdy = r1; disp_rs1_v = v1; disp_rs1_tag = t1;
    disp_rs2_rdy = r2; disp_rs2_v = v2; disp_rs2_tag = t2;
  endtask

  task automatic resp_pulse();
    fu_resp = 1'b1; cycle(); fu_resp = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs(); rst = 1'b1;
    cycle(); cycle();
    n_tests++; if (fu_en !== 1'b0) begin n_fail++; $display("FAIL reset_fu_en: got %0b want 0", fu_en); end
    n_tests++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    n_tests++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready: got %0b want 1", disp_ready); end
    n_tests++; if ({fu_instr, fu_rs1_v, fu_rs2_v, fu_rob} !== '0) begin n_fail++; $display("FAIL reset_fu_regs: got %0h want 0", {fu_instr, fu_rs1_v, fu_rs2_v, fu_rob}); end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_mul();
    disp(MUL, 2'd0, 1'b1, 32'd7, 2'd0, 1'b1, 32'd6, 2'd0);
    cycle(); idle_inputs();
    n_tests++; if (fu_en !== 1'b0) begin n_fail++; $display("FAIL mul_en_early: got %0b want 0", fu_en); end
    n_tests++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL mul_occ1: got %0d want 1", occupancy); end
    cycle();
    n_tests++; if (fu_en !== 1'b1) begin n_fail++; $display("FAIL mul_en: got %0b want 1", fu_en); end
    n_tests++; if (fu_rs1_v !== 32'd7 || fu_rs2_v !== 32'd6) begin n_fail++; $display("FAIL mul_ops: got %0d,%0d want 7,6", fu_rs1_v, fu_rs2_v); end
    n_tests++; if (fu_instr !== MUL) begin n_fail++; $display("FAIL mul_instr: got %0h want %0h", fu_instr, MUL); end
    n_tests++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL mul_occ0: got %0d want 0", occupancy); end
    repeat (3) cycle();
    n_tests++; if (fu_en !== 1'b1 || fu_rs1_v !== 32'd7 || fu_rs2_v !== 32'd6) begin n_fail++; $display("FAIL mul_hold: got en=%0b %0d,%0d want en=1 7,6", fu_en, fu_rs1_v, fu_rs2_v); end
    resp_pulse();
    n_tests++; if (fu_en !== 1'b0) begin n_fail++; $display("FAIL mul_drop: got %0b want 0", fu_en); end
    cycle();
    n_tests++; if (fu_en !== 1'b0) begin n_fail++; $display("FAIL mul_stay_idle: got %0b want 0", fu_en); end
  endtask

  task automatic test_wakeup();
    disp(DIV, 2'd1, 1'b1, 32'd20, 2'd0, 1'b0, 32'd0, 2'd2);
    cycle(); idle_inputs();
    cdb_valid = 1'b1; cdb_rob = 2'd1; cdb_data = 32'd99;
    cycle(); cdb_valid = 1'b0;
    cycle();
    n_tests++; if (fu_en !== 1'b0) begin n_fail++; $display("FAIL wake_wrong_tag: got %0b want 0", fu_en); end
    cdb_valid = 1'b1; cdb_rob = 2'd2; cdb_data = 32'd3;
    cycle(); cdb_valid = 1'b0;
    n_tests++; if (fu_en !== 1'b0) begin n_fail++; $display("FAIL wake_same_cycle: got %0b want 0", fu_en); end
    cycle();
    n_tests++; if (fu_en !== 1'b1 || fu_rs2_v !== 32'd3 || fu_rs1_v !== 32'd20) begin n_fail++; $display("FAIL wake_issue: got en=%0b %0d,%0d want en=1 20,3", fu_en, fu_rs1_v, fu_rs2_v); end
    n_tests++; if (fu_rob !== 2'd1 || fu_instr !== DIV) begin n_fail++; $display("FAIL wake_rob: got %0d %0h want 1 %0h", fu_rob, fu_instr, DIV); end
    resp_pulse(); cycle();
  endtask

  task automatic test_bypass();
    disp(MUL, 2'd2, 1'b0, 32'd0, 2'd3, 1'b1, 32'd5, 2'd0);
    cdb_valid = 1'b1; cdb_rob = 2'd3; cdb_data = 32'hDEAD_BEEF;
    cycle(); idle_inputs();
    cycle();
    n_tests++; if (fu_en !== 1'b1 || fu_rs1_v !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass: got en=%0b rs1=%0h want en=1 deadbeef", fu_en, fu_rs1_v); end
    resp_pulse(); cycle();
  endtask

  task automatic test_fill();
    disp(MUL, 2'd0, 1'b1, 32'd1, 2'd0, 1'b1, 32'd1, 2'd0);
    cycle(); idle_inputs(); cycle();
    for (int k = 0; k < 4; k++) begin
      disp(MUL, TAGW'(k), 1'b1, 32'd100 + 32'(k), 2'd0, 1'b1, 32'(k), 2'd0);
      cycle();
    end
    idle_inputs();
    n_tests++; if (disp_ready !== 1'b0 || occupancy !== 3'd4) begin n_fail++; $display("FAIL fill_full: got rdy=%0b occ=%0d want 0,4", disp_ready, occupancy); end
    disp(MUL, 2'd0, 1'b1, 32'd999, 2'd0, 1'b1, 32'd0, 2'd0);
    cycle(); cycle(); idle_inputs();
    n_tests++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL fill_drop: got occ=%0d want 4", occupancy); end
    resp_pulse();
    n_tests++; if (fu_en !== 1'b0 || disp_ready !== 1'b0) begin n_fail++; $display("FAIL fill_gap: got en=%0b rdy=%0b want 0,0", fu_en, disp_ready); end
    cycle();
    n_tests++; if (fu_en !== 1'b1 || fu_rs1_v !== 32'd100 || disp_ready !== 1'b1) begin n_fail++; $display("FAIL fill_issue0: got en=%0b rs1=%0d rdy=%0b want 1,100,1", fu_en, fu_rs1_v, disp_ready); end
    disp(MUL, 2'd0, 1'b1, 32'd200, 2'd0, 1'b1, 32'd0, 2'd0);
    cycle(); idle_inputs();
    n_tests++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL fill_refill: got occ=%0d want 4", occupancy); end
    exp_q = {32'd200, 32'd101, 32'd102, 32'd103};
    while (exp_q.size() > 0) begin
      resp_pulse(); cycle();
      n_tests++; if (fu_en !== 1'b1 || fu_rs1_v !== exp_q[0]) begin n_fail++; $display("FAIL fill_order: got en=%0b rs1=%0d want 1,%0d", fu_en, fu_rs1_v, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    resp_pulse();
    n_tests++; if (occupancy !== 3'd0 || fu_en !== 1'b0) begin n_fail++; $display("FAIL fill_drain: got occ=%0d en=%0b want 0,0", occupancy, fu_en); end
  endtask

  task automatic test_flush();
    disp(MUL, 2'd0, 1'b1, 32'd5, 2'd0, 1'b1, 32'd5, 2'd0);
    cycle(); idle_inputs(); cycle();
    for (int k = 0; k < 3; k++) begin
      disp(DIV, TAGW'(k + 1), 1'b1, 32'd50, 2'd0, 1'b1, 32'd2, 2'd0);
      cycle();
    end
    idle_inputs();
    n_tests++; if (occupancy !== 3'd3 || fu_en !== 1'b1) begin n_fail++; $display("FAIL flush_setup: got occ=%0d en=%0b want 3,1", occupancy, fu_en); end
    flush = 1'b1;
    disp(MUL, 2'd3, 1'b1, 32'd77, 2'd0, 1'b1, 32'd0, 2'd0);
    cycle(); idle_inputs();
    n_tests++; if (fu_en !== 1'b0 || occupancy !== 3'd0 || disp_ready !== 1'b1) begin n_fail++; $display("FAIL flush_clear: got en=%0b occ=%0d rdy=%0b want 0,0,1", fu_en, occupancy, disp_ready); end
    n_tests++; if (fu_rs1_v !== 32'd0 || fu_instr !== 32'd0) begin n_fail++; $display("FAIL flush_regs: got %0h %0h want 0 0", fu_rs1_v, fu_instr); end
    resp_pulse(); cycle();
    n_tests++; if (fu_en !== 1'b0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL flush_after_resp: got en=%0b occ=%0d want 0,0", fu_en, occupancy); end
  endtask

  task automatic test_priority();
    disp(MUL, 2'd2, 1'b1, 32'd1, 2'd0, 1'b1, 32'd1, 2'd0);
    cycle(); idle_inputs(); cycle();
    disp(MUL, 2'd0, 1'b0, 32'd0, 2'd1, 1'b1, 32'd0, 2'd0); cycle();
    disp(MUL, 2'd1, 1'b1, 32'd11, 2'd0, 1'b1, 32'd0, 2'd0); cycle();
    disp(MUL, 2'd2, 1'b0, 32'd0, 2'd1, 1'b1, 32'd0, 2'd0); cycle();
    disp(MUL, 2'd3, 1'b1, 32'd33, 2'd0, 1'b1, 32'd0, 2'd0); cycle();
    idle_inputs();
    resp_pulse();
    n_tests++; if (fu_en !== 1'b0) begin n_fail++; $display("FAIL prio_gap1: got %0b want 0", fu_en); end
    cycle();
    n_tests++; if (fu_en !== 1'b1 || fu_rs1_v !== 32'd11 || fu_rob !== 2'd1) begin n_fail++; $display("FAIL prio_first: got en=%0b rs1=%0d rob=%0d want 1,11,1", fu_en, fu_rs1_v, fu_rob); end
    resp_pulse();
    n_tests++; if (fu_en !== 1'b0) begin n_fail++; $display("FAIL prio_gap2: got %0b want 0", fu_en); end
    cycle();
    n_tests++; if (fu_en !== 1'b1 || fu_rs1_v !== 32'd33 || fu_rob !== 2'd3) begin n_fail++; $display("FAIL prio_second: got en=%0b rs1=%0d rob=%0d want 1,33,3", fu_en, fu_rs1_v, fu_rob); end
    flush = 1'b1; cycle(); flush = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      disp_valid   = ($urandom_range(0, 99) < 50);
      disp_instr   = {7'b0000001, 10'($urandom), 3'($urandom), 5'($urandom), 7'b0110011};
      disp_rob     = TAGW'($urandom_range(0, 3));
      disp_rs1_rdy = ($urandom_range(0, 99) < 60);
      disp_rs1_v   = $urandom;
      disp_rs1_tag = TAGW'($urandom_range(0, 3));
      disp_rs2_rdy = ($urandom_range(0, 99) < 60);
      disp_rs2_v   = $urandom;
      disp_rs2_tag = TAGW'($urandom_range(0, 3));
      cdb_valid    = ($urandom_range(0, 99) < 40);
      cdb_rob      = TAGW'($urandom_range(0, 3));
      cdb_data     = $urandom;
      fu_resp      = ($urandom_range(0, 99) < 35);
      flush        = ($urandom_range(0, 99) < 2);
      cycle();
      n_tests++; if (fu_en !== m_busy) begin n_fail++; $display("FAIL rnd_en c=%0d: got %0b want %0b", c, fu_en, m_busy); end
      n_tests++; if ({fu_instr, fu_rs1_v, fu_rs2_v, fu_rob} !== {m_instr, m_rs1, m_rs2, m_rob}) begin n_fail++; $display("FAIL rnd_fu c=%0d: got %0h %0h %0h %0d want %0h %0h %0h %0d", c, fu_instr, fu_rs1_v, fu_rs2_v, fu_rob, m_instr, m_rs1, m_rs2, m_rob); end
      n_tests++; if (occupancy !== m_occ[OW-1:0]) begin n_fail++; $display("FAIL rnd_occ c=%0d: got %0d want %0d", c, occupancy, m_occ); end
      n_tests++; if (disp_ready !== !m_full()) begin n_fail++; $display("FAIL rnd_ready c=%0d: got %0b want %0b", c, disp_ready, !m_full()); end
    end
    idle_inputs();
    flush = 1'b1; cycle(); flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mul();
    test_wakeup();
    test_bypass();
    test_fill();
    test_flush();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
